// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the Spartan-3E character-LCD bus blocks (read
// sequencer and write-enable pulse generator).
//   - lcd_state_e : read-sequencer state encodings
//   - lcd_nib_e   : nibble index (high nibble is transferred first)
//   - LCD_*_CYC   : default bus timing at a 50 MHz system clock
// ---------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [2:0] {
    LCD_ST_IDLE   = 3'd0,
    LCD_ST_SETUP  = 3'd1,
    LCD_ST_E_HIGH = 3'd2,
    LCD_ST_HOLD   = 3'd3,
    LCD_ST_GAP    = 3'd4,
    LCD_ST_DONE   = 3'd5
  } lcd_state_e;

  typedef enum logic {
    LCD_NIB_HIGH = 1'b0,
    LCD_NIB_LOW  = 1'b1
  } lcd_nib_e;

  // 50 MHz: 40 ns setup, 400 ns E high (covers tDDR 360 ns), 20 ns hold,
  // 1 us gap so a full E cycle comfortably exceeds the 1 us minimum.
  localparam int LCD_SETUP_CYC  = 2;
  localparam int LCD_E_HIGH_CYC = 20;
  localparam int LCD_HOLD_CYC   = 1;
  localparam int LCD_GAP_CYC    = 50;
  localparam int LCD_CNT_W      = 16;

endpackage

// File: rtl/lcd_phase_timer.sv
// ---------------------------------------------------------------------------
// lcd_phase_timer
// Phase counter for the LCD bus sequencers. Counts up from zero after a
// restart; expire_o is high while the count equals term_i. The owner restarts
// the timer on every phase change, so each phase lasts term_i+1 cycles.
// Ports:
//   Clock      system clock
//   Reset      asynchronous active-low reset
//   restart_i  force the count back to zero on the next edge
//   term_i     terminal count of the current phase (phase length - 1)
//   expire_o   current cycle is the last cycle of the phase
// ---------------------------------------------------------------------------
module lcd_phase_timer
  import lcd_pkg::*;
#(
  parameter int CNT_W = LCD_CNT_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             restart_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = restart_i ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == term_i);

endmodule

// File: rtl/lcd_read_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_read_sequencer
// HD44780-style 4-bit read on the Spartan-3E character LCD: two nibble reads,
// high nibble first. Used to poll busy flag / address counter (RS=0) or to
// read DDRAM/CGRAM (RS=1). Owns E/RW/RS during a transaction and raises
// oBusReq so the write path releases SF_D.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready for iStart, bus released
// SETUP   | RS/RW driven, E low, address setup time
// E_HIGH  | E high; nibble captured on the last cycle
// HOLD    | E low, RS/RW held for address hold time
// GAP     | E low, RW still 1; pads the E cycle, then next nibble or DONE
// DONE    | one-cycle oDone, RW back to 0, bus still owned for turnaround
//
// Ports:
//   Clock, Reset      50 MHz clock, asynchronous active-low reset
//   iStart, iRS       request and register select, sampled in IDLE only
//   iLCD_Data         SF_D[11:8] from the pad
//   oLCD_E/RW/RS      LCD control pins (registered)
//   oBusReq           this block owns the bus; FPGA data drivers must be off
//   oData, oBusyFlag  assembled byte and its bit 7
//   oDone, oReady     end-of-transaction pulse, idle indication
// ---------------------------------------------------------------------------
module lcd_read_sequencer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC  = LCD_SETUP_CYC,
  parameter int E_HIGH_CYC = LCD_E_HIGH_CYC,
  parameter int HOLD_CYC   = LCD_HOLD_CYC,
  parameter int GAP_CYC    = LCD_GAP_CYC,
  parameter int CNT_W      = LCD_CNT_W
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic       iRS,
  input  logic [3:0] iLCD_Data,
  output logic       oLCD_E,
  output logic       oLCD_RW,
  output logic       oLCD_RS,
  output logic       oBusReq,
  output logic [7:0] oData,
  output logic       oBusyFlag,
  output logic       oDone,
  output logic       oReady
);

  lcd_state_e       state_q;
  lcd_nib_e         nib_q;
  logic             e_q;
  logic             rw_q;
  logic             rs_q;
  logic             bus_req_q;
  logic [7:0]       data_q;
  logic             done_q;
  logic             ready_q;

  logic [CNT_W-1:0] cnt_term;
  logic             cnt_restart;
  logic             cnt_expire;

  always_comb begin
    cnt_term = '0;
    case (state_q)
      LCD_ST_SETUP:  cnt_term = CNT_W'(SETUP_CYC - 1);
      LCD_ST_E_HIGH: cnt_term = CNT_W'(E_HIGH_CYC - 1);
      LCD_ST_HOLD:   cnt_term = CNT_W'(HOLD_CYC - 1);
      LCD_ST_GAP:    cnt_term = CNT_W'(GAP_CYC - 1);
      default:       cnt_term = '0;
    endcase
  end

  // Every timed phase leaves on expire, so restarting on expire gives a
  // zero count at each state entry. IDLE/DONE keep the counter parked.
  assign cnt_restart = (state_q == LCD_ST_IDLE) || (state_q == LCD_ST_DONE) || cnt_expire;

  lcd_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .Clock     (Clock),
    .Reset     (Reset),
    .restart_i (cnt_restart),
    .term_i    (cnt_term),
    .expire_o  (cnt_expire)
  );

  // Outputs are assigned on the transition into each state so the pins come
  // straight from flops and E cannot glitch.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= LCD_ST_IDLE;
      nib_q     <= LCD_NIB_HIGH;
      e_q       <= 1'b0;
      rw_q      <= 1'b0;
      rs_q      <= 1'b0;
      bus_req_q <= 1'b0;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        LCD_ST_IDLE: begin
          if (iStart) begin
            state_q   <= LCD_ST_SETUP;
            nib_q     <= LCD_NIB_HIGH;
            rs_q      <= iRS;
            rw_q      <= 1'b1;
            bus_req_q <= 1'b1;
            ready_q   <= 1'b0;
          end
        end
        LCD_ST_SETUP: begin
          if (cnt_expire) begin
            state_q <= LCD_ST_E_HIGH;
            e_q     <= 1'b1;
          end
        end
        LCD_ST_E_HIGH: begin
          if (cnt_expire) begin
            state_q <= LCD_ST_HOLD;
            e_q     <= 1'b0;
            if (nib_q == LCD_NIB_HIGH) begin
              data_q[7:4] <= iLCD_Data;
            end else begin
              data_q[3:0] <= iLCD_Data;
            end
          end
        end
        LCD_ST_HOLD: begin
          if (cnt_expire) begin
            state_q <= LCD_ST_GAP;
          end
        end
        LCD_ST_GAP: begin
          if (cnt_expire) begin
            if (nib_q == LCD_NIB_HIGH) begin
              nib_q   <= LCD_NIB_LOW;
              state_q <= LCD_ST_SETUP;
            end else begin
              state_q <= LCD_ST_DONE;
              rw_q    <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        LCD_ST_DONE: begin
          // Bus stays requested one more cycle after RW drops so the LCD
          // has released SF_D before the FPGA drivers turn back on.
          state_q   <= LCD_ST_IDLE;
          bus_req_q <= 1'b0;
          rs_q      <= 1'b0;
          ready_q   <= 1'b1;
        end
        default: begin
          state_q <= LCD_ST_IDLE;
        end
      endcase
    end
  end

  assign oLCD_E    = e_q;
  assign oLCD_RW   = rw_q;
  assign oLCD_RS   = rs_q;
  assign oBusReq   = bus_req_q;
  assign oData     = data_q;
  assign oBusyFlag = data_q[7];
  assign oDone     = done_q;
  assign oReady    = ready_q;

endmodule

// File: tb/tb_lcd_read_sequencer.sv
module tb_lcd_read_sequencer;

  localparam int N = 160;

  logic       Clock;
  logic       Reset;
  logic       iStart;
  logic       iRS;
  logic [3:0] iLCD_Data;
  logic       oLCD_E, oLCD_RW, oLCD_RS, oBusReq, oBusyFlag, oDone, oReady;
  logic [7:0] oData;

  logic       rst_f;
  logic       f_start;
  logic       f_rs;
  logic [3:0] f_din;
  logic       f_e, f_rw, f_rsout, f_busreq, f_busy, f_done, f_ready;
  logic [7:0] f_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic       e_s    [0:N-1];
  logic       rw_s   [0:N-1];
  logic       br_s   [0:N-1];
  logic       done_s [0:N-1];
  logic       rdy_s  [0:N-1];
  logic [7:0] data_s [0:N-1];
  int         done_cnt, e_high_cnt, rs_bad_cnt;

  lcd_read_sequencer dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iStart    (iStart),
    .iRS       (iRS),
    .iLCD_Data (iLCD_Data),
    .oLCD_E    (oLCD_E),
    .oLCD_RW   (oLCD_RW),
    .oLCD_RS   (oLCD_RS),
    .oBusReq   (oBusReq),
    .oData     (oData),
    .oBusyFlag (oBusyFlag),
    .oDone     (oDone),
    .oReady    (oReady)
  );

  lcd_read_sequencer #(
    .SETUP_CYC  (1),
    .E_HIGH_CYC (1),
    .HOLD_CYC   (1),
    .GAP_CYC    (1)
  ) dut_f (
    .Clock     (Clock),
    .Reset     (rst_f),
    .iStart    (f_start),
    .iRS       (f_rs),
    .iLCD_Data (f_din),
    .oLCD_E    (f_e),
    .oLCD_RW   (f_rw),
    .oLCD_RS   (f_rsout),
    .oBusReq   (f_busreq),
    .oData     (f_data),
    .oBusyFlag (f_busy),
    .oDone     (f_done),
    .oReady    (f_ready)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample t is taken just after the t-th edge following the edge that
  // sampled iStart; the LCD's data switches to the low nibble once E falls.
  task automatic run_txn(input logic rs, input logic [3:0] dhi, input logic [3:0] dlo,
                         input bit disturb);
    iRS = rs;
    iStart = 1'b1;
    iLCD_Data = dhi;
    tick();
    iStart = 1'b0;
    done_cnt = 0;
    e_high_cnt = 0;
    rs_bad_cnt = 0;
    for (int t = 0; t < N; t++) begin
      e_s[t]    = oLCD_E;
      rw_s[t]   = oLCD_RW;
      br_s[t]   = oBusReq;
      done_s[t] = oDone;
      rdy_s[t]  = oReady;
      data_s[t] = oData;
      if (oDone) done_cnt++;
      if (oLCD_E) e_high_cnt++;
      if (t <= 146 && oLCD_RS !== rs) rs_bad_cnt++;
      if (t > 0 && e_s[t-1] && !oLCD_E) iLCD_Data = dlo;
      if (disturb) begin
        if (t == 10) begin
          iStart = 1'b1;
          iRS = ~rs;
        end
        if (t == 11) iStart = 1'b0;
        if (t == 80) iRS = rs;
        if (t == 90) iRS = ~rs;
      end
      tick();
    end
  endtask

  initial begin
    int fd[3];
    int fdn;
    int f_rdy_between;

    Reset = 1'b0;
    iStart = 1'b0;
    iRS = 1'b0;
    iLCD_Data = 4'h0;
    rst_f = 1'b0;
    f_start = 1'b1;
    f_rs = 1'b0;
    f_din = 4'h6;
    repeat (3) tick();

    check("rst_e", oLCD_E, 1'b0);
    check("rst_rw", oLCD_RW, 1'b0);
    check("rst_rs", oLCD_RS, 1'b0);
    check("rst_busreq", oBusReq, 1'b0);
    check("rst_data", oData, 8'h00);
    check("rst_done", oDone, 1'b0);
    check("rst_ready", oReady, 1'b1);
    Reset = 1'b1;
    repeat (2) tick();
    check("idle_ready", oReady, 1'b1);

    // Busy-flag read: 0x8 then 0x3.
    run_txn(1'b0, 4'h8, 4'h3, 1'b0);
    check("t1_setup_rw", rw_s[0], 1'b1);
    check("t1_setup_busreq", br_s[0], 1'b1);
    check("t1_setup_ready", rdy_s[0], 1'b0);
    check("t1_e_before_rise", e_s[1], 1'b0);
    check("t1_e_rise1", e_s[2], 1'b1);
    check("t1_e_last1", e_s[21], 1'b1);
    check("t1_e_fall1", e_s[22], 1'b0);
    check("t1_data_before_cap", data_s[21], 8'h00);
    check("t1_data_high_nib", data_s[22], 8'h80);
    check("t1_rw_gap_end1", rw_s[72], 1'b1);
    check("t1_e_before_rise2", e_s[74], 1'b0);
    check("t1_e_rise2", e_s[75], 1'b1);
    check("t1_e_last2", e_s[94], 1'b1);
    check("t1_e_fall2", e_s[95], 1'b0);
    check("t1_e_high_total", e_high_cnt, 40);
    check("t1_rw_gap_end2", rw_s[145], 1'b1);
    check("t1_done_early", done_s[145], 1'b0);
    check("t1_done_at", done_s[146], 1'b1);
    check("t1_done_count", done_cnt, 1);
    check("t1_rw_in_done", rw_s[146], 1'b0);
    check("t1_busreq_in_done", br_s[146], 1'b1);
    check("t1_busreq_after", br_s[147], 1'b0);
    check("t1_ready_after", rdy_s[147], 1'b1);
    check("t1_data", data_s[147], 8'h83);
    check("t1_busy", oBusyFlag, 1'b1);
    check("t1_rs", rs_bad_cnt, 0);

    // Data read with RS=1, plus stray iStart and iRS toggles mid-transaction.
    run_txn(1'b1, 4'h4, 4'h1, 1'b1);
    check("t2_data_high_nib", data_s[22], 8'h43);
    check("t2_rs_held", rs_bad_cnt, 0);
    check("t2_done_at", done_s[146], 1'b1);
    check("t2_done_count", done_cnt, 1);
    check("t2_data", data_s[150], 8'h41);
    check("t2_busy", oBusyFlag, 1'b0);
    check("t2_ready_end", rdy_s[N-1], 1'b1);

    // Abort during the second E_HIGH.
    iRS = 1'b1;
    iStart = 1'b1;
    iLCD_Data = 4'hC;
    tick();
    iStart = 1'b0;
    repeat (79) tick();
    check("ab_pre_e", oLCD_E, 1'b1);
    check("ab_pre_data", oData, 8'hC1);
    #3 Reset = 1'b0;
    #1;
    check("ab_e", oLCD_E, 1'b0);
    check("ab_rw", oLCD_RW, 1'b0);
    check("ab_rs", oLCD_RS, 1'b0);
    check("ab_busreq", oBusReq, 1'b0);
    check("ab_data", oData, 8'h00);
    check("ab_done", oDone, 1'b0);
    check("ab_ready", oReady, 1'b1);
    done_cnt = 0;
    repeat (4) begin
      tick();
      if (oDone) done_cnt++;
    end
    Reset = 1'b1;
    repeat (80) begin
      tick();
      if (oDone) done_cnt++;
    end
    check("ab_no_done", done_cnt, 0);

    run_txn(1'b0, 4'hA, 4'h5, 1'b0);
    check("t3_done_at", done_s[146], 1'b1);
    check("t3_done_count", done_cnt, 1);
    check("t3_data", data_s[150], 8'hA5);
    check("t3_busy", oBusyFlag, 1'b1);

    // Minimum timing with iStart tied high: one DONE every 10 cycles.
    rst_f = 1'b1;
    fdn = 0;
    f_rdy_between = 0;
    fd[0] = -1;
    fd[1] = -1;
    fd[2] = -1;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (f_done && fdn < 3) begin
        fd[fdn] = t;
        fdn++;
      end
      if (fdn == 1 && f_ready) f_rdy_between++;
    end
    check("f_done_first", fd[0], 8);
    check("f_period1", fd[1] - fd[0], 10);
    check("f_period2", fd[2] - fd[1], 10);
    check("f_ready_cycles", f_rdy_between, 1);
    check("f_data", f_data, 8'h66);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
